// File: rtl/glitch_sequencer.sv
// glitch_sequencer: N_CH independent fault-pulse channels sharing one
// arm/trigger path. Each channel runs offset -> (pulse, gap)* from shadow
// copies latched at the trigger event.
// Optional macro GLITCH_TRIG_SYNC_EN: 2-flop synchroniser on trigger_in.
module glitch_sequencer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 32,
  parameter bit          FAULT_POL   = 1'b1,
  parameter bit          AUTO_DISARM = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(N_CH)+1:0]   cfg_addr,
  input  logic [CNT_W-1:0]          cfg_wdata,
  output logic [CNT_W-1:0]          cfg_rdata,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic                      sw_trigger,
  input  logic                      trigger_in,
  output logic [N_CH-1:0]           fault_out,
  output logic [N_CH-1:0]           busy,
  output logic                      armed,
  output logic                      done
);

  localparam int unsigned AW = $clog2(N_CH) + 2;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OFFSET, PULSE, GAP} state_t;

  logic [CNT_W-1:0] off_r [N_CH];
  logic [CNT_W-1:0] wid_r [N_CH];
  logic [CNT_W-1:0] rep_r [N_CH];
  logic [CNT_W-1:0] gap_r [N_CH];
  logic [CNT_W-1:0] off_s [N_CH];
  logic [CNT_W-1:0] wid_s [N_CH];
  logic [CNT_W-1:0] rep_s [N_CH];
  logic [CNT_W-1:0] gap_s [N_CH];

  state_t           state_q [N_CH];
  state_t           state_n [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_n   [N_CH];
  logic [CNT_W-1:0] pls_q   [N_CH];
  logic [CNT_W-1:0] pls_n   [N_CH];

  logic [AW-1:0]    cfg_ch;
  logic [CNT_W-1:0] rd_mux;
  logic             trig_s;
  logic             trig_prev;
  logic             trig_fire;
  logic             busy_any;
  logic             busy_any_n;

  assign cfg_ch = cfg_addr >> 2;

`ifdef GLITCH_TRIG_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchroniser; keeps sampling during reset so a level held
  // through reset is not seen as an edge afterwards.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], trigger_in};
  end
  assign trig_s = sync_q[1];
`else
  assign trig_s = trigger_in;
`endif

  // Edge-detect history flop, deliberately loaded during reset as well.
  always_ff @(posedge clk) begin
    trig_prev <= trig_s;
  end

  // Busy decode from channel state.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      busy[i] = (state_q[i] != IDLE);
    end
  end

  assign busy_any  = |busy;
  assign trig_fire = ((trig_s & ~trig_prev) | sw_trigger) & armed & ~busy_any & ~disarm;

  // Per-channel next-state and counter logic.
  always_comb begin
    busy_any_n = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_n[i] = state_q[i];
      cnt_n[i]   = cnt_q[i];
      pls_n[i]   = pls_q[i];
      if (disarm) begin
        state_n[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (trig_fire && (rep_r[i] != '0) && (wid_r[i] != '0)) begin
              cnt_n[i]   = '0;
              pls_n[i]   = '0;
              state_n[i] = (off_r[i] == '0) ? PULSE : OFFSET;
            end
          end
          OFFSET: begin
            if (cnt_q[i] == off_s[i] - ONE) begin
              cnt_n[i]   = '0;
              state_n[i] = PULSE;
            end else begin
              cnt_n[i] = cnt_q[i] + ONE;
            end
          end
          PULSE: begin
            if (cnt_q[i] == wid_s[i] - ONE) begin
              cnt_n[i] = '0;
              if (pls_q[i] == rep_s[i] - ONE) begin
                state_n[i] = IDLE;
              end else begin
                pls_n[i]   = pls_q[i] + ONE;
                state_n[i] = GAP;
              end
            end else begin
              cnt_n[i] = cnt_q[i] + ONE;
            end
          end
          GAP: begin
            // gap of 0 behaves as a 1-cycle gap
            if ((gap_s[i] == '0) || (cnt_q[i] == gap_s[i] - ONE)) begin
              cnt_n[i]   = '0;
              state_n[i] = PULSE;
            end else begin
              cnt_n[i] = cnt_q[i] + ONE;
            end
          end
          default: state_n[i] = IDLE;
        endcase
      end
      if (state_n[i] != IDLE) busy_any_n = 1'b1;
    end
  end

  // Channel state, counters, shadows, registered glitch pins and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pls_q[i]   <= '0;
        off_s[i]   <= '0;
        wid_s[i]   <= '0;
        rep_s[i]   <= '0;
        gap_s[i]   <= '0;
      end
      fault_out <= {N_CH{~FAULT_POL}};
      armed     <= 1'b0;
      done      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i]   <= state_n[i];
        cnt_q[i]     <= cnt_n[i];
        pls_q[i]     <= pls_n[i];
        fault_out[i] <= (state_n[i] == PULSE) ? FAULT_POL : ~FAULT_POL;
        if (trig_fire) begin
          off_s[i] <= off_r[i];
          wid_s[i] <= wid_r[i];
          rep_s[i] <= rep_r[i];
          gap_s[i] <= gap_r[i];
        end
      end
      done <= busy_any & ~busy_any_n & ~disarm;
      if (disarm)                                            armed <= 1'b0;
      else if (arm)                                          armed <= 1'b1;
      else if (AUTO_DISARM && busy_any && !busy_any_n)       armed <= 1'b0;
    end
  end

  // Host-visible configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        off_r[i] <= '0;
        wid_r[i] <= ONE;
        rep_r[i] <= ONE;
        gap_r[i] <= ONE;
      end
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cfg_ch == AW'(i)) begin
          case (cfg_addr[1:0])
            2'd0:    off_r[i] <= cfg_wdata;
            2'd1:    wid_r[i] <= cfg_wdata;
            2'd2:    rep_r[i] <= cfg_wdata;
            default: gap_r[i] <= cfg_wdata;
          endcase
        end
      end
    end
  end

  // Read mux; unmapped channels read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg_ch == AW'(i)) begin
        case (cfg_addr[1:0])
          2'd0:    rd_mux = off_r[i];
          2'd1:    rd_mux = wid_r[i];
          2'd2:    rd_mux = rep_r[i];
          default: rd_mux = gap_r[i];
        endcase
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (rst) cfg_rdata <= '0;
    else     cfg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
module tb_glitch_sequencer;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
`ifdef GLITCH_TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int K_FAULT = 0;
  localparam int K_BUSY  = 1;
  localparam int K_ARMED = 2;
  localparam int K_DONE  = 3;
  localparam int K_RDATA = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_addr = '0;
  logic [CNT_W-1:0]  cfg_wdata = '0;
  logic [CNT_W-1:0]  cfg_rdata;
  logic              arm = 1'b0;
  logic              disarm = 1'b0;
  logic              sw_trigger = 1'b0;
  logic              trigger_in = 1'b0;
  logic [N_CH-1:0]   fault_out;
  logic [N_CH-1:0]   busy;
  logic              armed;
  logic              done;

  glitch_sequencer #(
    .N_CH(N_CH), .CNT_W(CNT_W), .FAULT_POL(1'b1), .AUTO_DISARM(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .arm(arm), .disarm(disarm),
    .sw_trigger(sw_trigger), .trigger_in(trigger_in), .fault_out(fault_out),
    .busy(busy), .armed(armed), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void expect_at(int c, int kind, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = v; e.nm = nm;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_FAULT: act = {28'b0, fault_out};
          K_BUSY:  act = {28'b0, busy};
          K_ARMED: act = {31'b0, armed};
          K_DONE:  act = {31'b0, done};
          default: act = cfg_rdata;
        endcase
        n_total++;
        if (act === sb[i].val) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h want %0h", sb[i].nm, cyc, act, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick;
  endtask

  task automatic wr(int ch, int r, logic [31:0] v);
    cfg_we = 1'b1; cfg_addr = 4'((ch << 2) | r); cfg_wdata = v;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic rd_chk(int ch, int r, logic [31:0] v, string nm);
    cfg_addr = 4'((ch << 2) | r);
    expect_at(cyc + 1, K_RDATA, v, nm);
    tick;
  endtask

  task automatic do_arm;
    arm = 1'b1; tick; arm = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, r, d, c;
    tick; tick;
    rst = 1'b0;
    n_total++;
    if (fault_out === 4'b0000) n_pass++;
    else $display("FAIL rst_fault_direct: got %0h want 0", fault_out);
    n_total++;
    if (busy === 4'b0000) n_pass++;
    else $display("FAIL rst_busy_direct: got %0h want 0", busy);
    n_total++;
    if (armed === 1'b0) n_pass++;
    else $display("FAIL rst_armed_direct: got %0h want 0", armed);
    expect_at(cyc, K_FAULT, 0, "rst_fault");
    expect_at(cyc, K_BUSY,  0, "rst_busy");
    expect_at(cyc, K_ARMED, 0, "rst_armed");
    expect_at(cyc, K_DONE,  0, "rst_done");
    expect_at(cyc, K_RDATA, 0, "rst_rdata");
    rd_chk(0, 0, 0, "rst_offset");
    rd_chk(0, 1, 1, "rst_width");
    rd_chk(1, 2, 1, "rst_repeat");
    rd_chk(3, 3, 1, "rst_gap");

    wr(1, 2, 0); wr(2, 2, 0); wr(3, 2, 0);
    wr(0, 0, 5); wr(0, 1, 3);
    do_arm;
    e = cyc; sw_trigger = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      expect_at(e + k, K_FAULT, (k >= 6 && k <= 8) ? 1 : 0, "t1_fault");
      expect_at(e + k, K_BUSY,  (k >= 1 && k <= 8) ? 1 : 0, "t1_busy");
      expect_at(e + k, K_DONE,  (k == 9) ? 1 : 0, "t1_done");
      expect_at(e + k, K_ARMED, (k <= 8) ? 1 : 0, "t1_armed");
    end
    tick; sw_trigger = 1'b0;
    wait_until(e + 11);

    do_arm;
    e = cyc; sw_trigger = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      expect_at(e + k, K_FAULT, (k >= 6 && k <= 8) ? 1 : 0, "t2_fault_old");
      expect_at(e + k, K_DONE,  (k == 9) ? 1 : 0, "t2_done_old");
    end
    tick; sw_trigger = 1'b0;
    wait_until(e + 7);
    wr(0, 1, 9);
    wait_until(e + 11);
    rd_chk(0, 1, 9, "t2_rd_width");
    do_arm;
    e2 = cyc; sw_trigger = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      expect_at(e2 + k, K_FAULT, (k >= 6 && k <= 14) ? 1 : 0, "t2_fault_new");
      expect_at(e2 + k, K_DONE,  (k == 15) ? 1 : 0, "t2_done_new");
    end
    tick; sw_trigger = 1'b0;
    wait_until(e2 + 17);

    wr(0, 2, 0); wr(1, 1, 2); wr(1, 2, 3); wr(1, 3, 4);
    do_arm;
    e = cyc; sw_trigger = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      expect_at(e + k, K_FAULT,
                (k == 1 || k == 2 || k == 7 || k == 8 || k == 13 || k == 14) ? 2 : 0, "t3_fault");
      expect_at(e + k, K_BUSY,  (k >= 1 && k <= 14) ? 2 : 0, "t3_busy");
      expect_at(e + k, K_DONE,  (k == 15) ? 1 : 0, "t3_done");
    end
    expect_at(e + 15, K_ARMED, 0, "t3_armed");
    tick; sw_trigger = 1'b0;
    wait_until(e + 17);

    wr(1, 2, 0); wr(2, 0, 10); wr(2, 2, 1);
    do_arm;
    e = cyc; sw_trigger = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      expect_at(e + k, K_FAULT, (k == 11) ? 4 : 0, "t4_fault");
      expect_at(e + k, K_BUSY,  (k >= 1 && k <= 11) ? 4 : 0, "t4_busy");
      expect_at(e + k, K_DONE,  (k == 12) ? 1 : 0, "t4_done");
    end
    tick; sw_trigger = 1'b0;
    wait_until(e + 15);

    do_arm;
    e = cyc; sw_trigger = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      expect_at(e + k, K_FAULT, 0, "t5_fault");
      expect_at(e + k, K_DONE,  0, "t5_done");
      expect_at(e + k, K_BUSY,  (k >= 1 && k <= 3) ? 4 : 0, "t5_busy");
      expect_at(e + k, K_ARMED, (k <= 3) ? 1 : 0, "t5_armed");
    end
    tick; sw_trigger = 1'b0;
    wait_until(e + 3);
    disarm = 1'b1; tick; disarm = 1'b0;
    wait_until(e + 6);
    sw_trigger = 1'b1; tick; sw_trigger = 1'b0;
    wait_until(e + 16);
    c = cyc;
    arm = 1'b1; disarm = 1'b1;
    expect_at(c + 1, K_ARMED, 0, "t5_arm_vs_disarm");
    expect_at(c + 2, K_ARMED, 0, "t5_arm_vs_disarm2");
    tick; arm = 1'b0; disarm = 1'b0;
    wait_until(c + 3);

    do_arm;
    r = cyc; e = r + LAT; trigger_in = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      expect_at(e + k, K_BUSY,  (k >= 1 && k <= 11) ? 4 : 0, "t6_busy");
      expect_at(e + k, K_FAULT, (k == 11) ? 4 : 0, "t6_fault");
      expect_at(e + k, K_DONE,  (k == 12) ? 1 : 0, "t6_done");
    end
    expect_at(e + 12, K_ARMED, 0, "t6_armed");
    tick; tick; trigger_in = 1'b0;
    tick; tick; trigger_in = 1'b1;
    repeat (5) tick;
    trigger_in = 1'b0;
    wait_until(e + 15);

    trigger_in = 1'b1; rst = 1'b1;
    tick; tick; tick;
    rst = 1'b0;
    d = cyc;
    expect_at(d, K_ARMED, 0, "t7_armed_rst");
    expect_at(d, K_BUSY,  0, "t7_busy_rst");
    expect_at(d, K_FAULT, 0, "t7_fault_rst");
    do_arm;
    for (int k = 1; k <= 8; k++) begin
      expect_at(d + k, K_BUSY, 0, "t7_no_edge");
    end
    expect_at(d + 1, K_ARMED, 1, "t7_armed");
    wait_until(d + 9);
    trigger_in = 1'b0;
    rd_chk(2, 0, 0, "t7_rd_offset");
    rd_chk(0, 1, 1, "t7_rd_width");
    tick; tick;

    foreach (sb[i]) begin
      n_total++;
      $display("FAIL %s stale expectation for cycle %0d: got none want %0h", sb[i].nm, sb[i].cyc, sb[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
